// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch/countdown timer block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_DONE    = 2'b11
  } status_t;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic       MODE_UP   = 1'b0;
  localparam logic       MODE_DOWN = 1'b1;

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_PER_SEC enabled cycles.
module tick_prescaler #(
  parameter int CLK_PER_SEC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

  logic [CW-1:0] cnt;

  // The count only moves while enabled, so a pause keeps the partial second.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown timer: control FSM, MM:SS counters, lap capture, expiry pulse.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_PER_SEC = 1000,
  parameter int MIN_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             lap,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_valid,
  output logic [1:0]       status,
  output logic             expired
);

  status_t state;
  logic    mode_q;
  logic    tick;
  logic    load_ok;
  logic    at_zero;
  logic    ps_en;
  logic [5:0] load_sec_c;

  assign status     = state;
  assign load_ok    = load && (state != ST_RUNNING);
  assign at_zero    = (minutes == '0) && (seconds == '0);
  assign load_sec_c = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
  // A stop cycle is already treated as paused, so it never ticks.
  assign ps_en      = (state == ST_RUNNING) && !stop && !clear;

  tick_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ps_en),
    .clr  (clear || load_ok),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_UP;
      minutes   <= '0;
      seconds   <= '0;
      lap_min   <= '0;
      lap_sec   <= '0;
      lap_valid <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clear) begin
        state     <= ST_IDLE;
        minutes   <= '0;
        seconds   <= '0;
        lap_min   <= '0;
        lap_sec   <= '0;
        lap_valid <= 1'b0;
      end else begin
        // Lap samples the pre-edge count, so a lap on a tick cycle sees the old value.
        if (lap && (state == ST_RUNNING || state == ST_PAUSED)) begin
          lap_min   <= minutes;
          lap_sec   <= seconds;
          lap_valid <= 1'b1;
        end
        if (load_ok) begin
          minutes <= load_min;
          seconds <= load_sec_c;
          if (state != ST_PAUSED)
            state <= ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: begin
              if (start && !stop && !(mode == MODE_DOWN && at_zero)) begin
                state  <= ST_RUNNING;
                mode_q <= mode;
              end
            end
            ST_RUNNING: begin
              if (stop) begin
                state <= ST_PAUSED;
              end else if (tick) begin
                if (mode_q == MODE_UP) begin
                  if (seconds == SEC_MAX) begin
                    seconds <= '0;
                    minutes <= minutes + MIN_W'(1);
                  end else begin
                    seconds <= seconds + 6'd1;
                  end
                end else if (seconds != '0) begin
                  seconds <= seconds - 6'd1;
                  if (seconds == 6'd1 && minutes == '0) begin
                    state   <= ST_DONE;
                    expired <= 1'b1;
                  end
                end else if (minutes != '0) begin
                  seconds <= SEC_MAX;
                  minutes <= minutes - MIN_W'(1);
                end else begin
                  // Resumed at 00:00 in down mode: expire on the first tick.
                  state   <= ST_DONE;
                  expired <= 1'b1;
                end
              end
            end
            ST_PAUSED: begin
              if (start && !stop)
                state <= ST_RUNNING;
            end
            ST_DONE: ;
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Cycle scoreboard against a total-seconds reference model, plus directed checks.
module tb_stopwatch_timer;
  localparam int CPS   = 4;
  localparam int MW    = 2;
  localparam int TOTAL = (1 << MW) * 60;

  logic          clk = 1'b0;
  logic          rst, start, stop, clear, mode, load, lap;
  logic [MW-1:0] load_min;
  logic [5:0]    load_sec;
  logic [MW-1:0] minutes, lap_min;
  logic [5:0]    seconds, lap_sec;
  logic          lap_valid, expired;
  logic [1:0]    status;

  stopwatch_timer #(.CLK_PER_SEC(CPS), .MIN_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .mode(mode), .load(load), .load_min(load_min), .load_sec(load_sec),
    .lap(lap), .minutes(minutes), .seconds(seconds), .lap_min(lap_min),
    .lap_sec(lap_sec), .lap_valid(lap_valid), .status(status), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mn; int sc; int lm; int ls; int lv; int st; int ex;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference state: time kept as total seconds
  int m_st, m_t, m_ps, m_mode, m_lt, m_lv, m_ex;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    if (rst) begin
      m_st = 0; m_t = 0; m_ps = 0; m_mode = 0; m_lt = 0; m_lv = 0; m_ex = 0;
    end else begin
      m_ex = 0;
      if (clear) begin
        m_st = 0; m_t = 0; m_ps = 0; m_lt = 0; m_lv = 0;
      end else begin
        if (lap && (m_st == 1 || m_st == 2)) begin m_lt = m_t; m_lv = 1; end
        if (load && m_st != 1) begin
          m_t  = int'(load_min) * 60 + ((int'(load_sec) > 59) ? 59 : int'(load_sec));
          m_ps = 0;
          if (m_st != 2) m_st = 0;
        end else begin
          case (m_st)
            0: if (start && !stop && !(mode && m_t == 0)) begin m_st = 1; m_mode = int'(mode); end
            1: begin
              if (stop) m_st = 2;
              else if (m_ps == CPS - 1) begin
                m_ps = 0;
                if (m_mode == 0) m_t = (m_t + 1) % TOTAL;
                else begin
                  if (m_t > 0) m_t--;
                  if (m_t == 0) begin m_st = 3; m_ex = 1; end
                end
              end else m_ps++;
            end
            2: if (start && !stop) m_st = 1;
            default: ;
          endcase
        end
      end
    end
    e.mn = m_t / 60; e.sc = m_t % 60; e.lm = m_lt / 60; e.ls = m_lt % 60;
    e.lv = m_lv; e.st = m_st; e.ex = m_ex;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("minutes", int'(minutes), e.mn);
    chk("seconds", int'(seconds), e.sc);
    chk("lap_min", int'(lap_min), e.lm);
    chk("lap_sec", int'(lap_sec), e.ls);
    chk("lap_valid", int'(lap_valid), e.lv);
    chk("status", int'(status), e.st);
    chk("expired", int'(expired), e.ex);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cmd(input bit s, input bit p, input bit c, input bit l, input bit lp);
    start = s; stop = p; clear = c; load = l; lap = lp;
    step();
    start = 0; stop = 0; clear = 0; load = 0; lap = 0;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; clear = 0; mode = 0; load = 0; lap = 0;
    load_min = '0; load_sec = '0;
    idle(2);
    rst = 0;
    chk("rst_status", int'(status), 0);
    chk("rst_sec", int'(seconds), 0);
    chk("rst_lapv", int'(lap_valid), 0);

    // Free run 61 seconds from 00:00
    cmd(1, 0, 0, 0, 0);
    idle(4 * 61);
    chk("run_min", int'(minutes), 1);
    chk("run_sec", int'(seconds), 1);
    chk("run_status", int'(status), 1);

    // Pause keeps partial prescaler count
    cmd(0, 0, 1, 0, 0);
    cmd(1, 0, 0, 0, 0);
    idle(40);
    chk("up10_sec", int'(seconds), 10);
    idle(2);
    cmd(0, 1, 0, 0, 0);
    idle(20);
    chk("pause_sec", int'(seconds), 10);
    chk("pause_status", int'(status), 2);
    cmd(1, 0, 0, 0, 0);
    step();
    chk("resume_pre", int'(seconds), 10);
    step();
    chk("resume_tick", int'(seconds), 11);

    // Load while paused stays paused
    load_min = 2'd2; load_sec = 6'd30;
    cmd(0, 1, 0, 0, 0);
    cmd(0, 0, 0, 1, 0);
    chk("pload_status", int'(status), 2);
    chk("pload_min", int'(minutes), 2);

    // Lap on a tick cycle captures the pre-tick value
    cmd(0, 0, 1, 0, 0);
    cmd(1, 0, 0, 0, 0);
    idle(20 + 3);
    cmd(0, 0, 0, 0, 1);
    chk("lap_sec_t", int'(lap_sec), 5);
    chk("lap_cur_sec", int'(seconds), 6);
    chk("lap_valid_t", int'(lap_valid), 1);
    cmd(0, 0, 1, 0, 0);
    chk("lap_clr", int'(lap_valid), 0);

    // Countdown 00:03 to expiry
    mode = 1; load_min = 2'd0; load_sec = 6'd3;
    cmd(0, 0, 0, 1, 0);
    cmd(1, 0, 0, 0, 0);
    idle(4);
    chk("dn_2", int'(seconds), 2);
    idle(4);
    chk("dn_1", int'(seconds), 1);
    idle(4);
    chk("dn_0", int'(seconds), 0);
    chk("dn_exp", int'(expired), 1);
    chk("dn_done", int'(status), 3);
    cmd(1, 0, 0, 0, 0);
    chk("dn_exp_once", int'(expired), 0);
    chk("done_start", int'(status), 3);
    cmd(0, 0, 1, 0, 0);
    chk("done_clear", int'(status), 0);

    // Down-mode start at 00:00 ignored; start+stop in IDLE ignored
    cmd(1, 0, 0, 0, 0);
    chk("dn_zero_start", int'(status), 0);
    mode = 0;
    cmd(1, 1, 0, 0, 0);
    chk("startstop_idle", int'(status), 0);

    // Seconds clamp
    load_min = 2'd0; load_sec = 6'd63;
    cmd(0, 0, 0, 1, 0);
    chk("clamp_sec", int'(seconds), 59);

    // Top-of-range wrap in up mode
    load_min = 2'd3; load_sec = 6'd59;
    cmd(0, 0, 0, 1, 0);
    cmd(1, 0, 0, 0, 0);
    idle(4);
    chk("wrap_min", int'(minutes), 0);
    chk("wrap_sec", int'(seconds), 0);
    chk("wrap_status", int'(status), 1);

    // Lap then reset mid-run
    idle(6);
    cmd(0, 0, 0, 0, 1);
    idle(3);
    rst = 1;
    step();
    rst = 0;
    chk("rst_run_status", int'(status), 0);
    chk("rst_run_sec", int'(seconds), 0);
    chk("rst_run_lapv", int'(lap_valid), 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
